// File: rtl/axi_rng_master_if.sv
// axi_rng_master_if: single-beat AXI4 AR/R/AW/W/B channels between the RNG master and the RNG register slave
interface axi_rng_master_if;
  logic [15:0] ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [15:0] RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [15:0] AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [15:0] BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID, AWREADY, WREADY, BID, BRESP, BVALID
  );
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi_rng_master.sv
// axi_rng_master: single-outstanding AXI initiator turning cmd/rsp requests into single-beat reads and writes
module axi_rng_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [15:0] rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        timeout_err,
  output logic [15:0] txn_count,
  axi_rng_master_if.master m
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, RSP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  state_t state, state_n;
  logic [CW-1:0] wait_cnt;
  logic [15:0] id_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic write_q, aw_done, w_done;
  logic cmd_hs, aw_hs, w_hs, waiting;
  assign cmd_ready = state == IDLE;
  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs = m.AWVALID & m.AWREADY;
  assign w_hs = m.WVALID & m.WREADY;
  assign waiting = state inside {RADDR, RDATA, WADDR, WRESP};
  assign m.ARVALID = state == RADDR;
  assign m.RREADY = state == RDATA;
  assign m.AWVALID = (state == WADDR) & !aw_done;
  assign m.WVALID = (state == WADDR) & !w_done;
  assign m.BREADY = state == WRESP;
  assign m.ARID = id_q;
  assign m.ARADDR = addr_q;
  assign m.ARLEN = 4'd0;
  assign m.ARSIZE = 3'b010;
  assign m.ARBURST = 2'b01;
  assign m.AWID = id_q;
  assign m.AWADDR = addr_q;
  assign m.AWLEN = 4'd0;
  assign m.AWSIZE = 3'b010;
  assign m.AWBURST = 2'b01;
  assign m.WDATA = wdata_q;
  assign m.WSTRB = {4'b0, wstrb_q};
  assign rsp_valid = state == RSP;
  assign rsp_write = write_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_hs) state_n = cmd_write ? WADDR : RADDR;
      RADDR:   if (m.ARREADY) state_n = RDATA;
      RDATA:   if (m.RVALID) state_n = RSP;
      WADDR:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_n = WRESP;
      WRESP:   if (m.BVALID) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      write_q <= 1'b0;
      id_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_resp <= '0;
      txn_count <= '0;
    end else begin
      if (cmd_hs) begin
        write_q <= cmd_write;
        id_q <= cmd_id;
        addr_q <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        wait_cnt <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      // counter saturates at the limit; the flag sets on the step that reaches it
      if (waiting && wait_cnt < CW'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + 1'b1;
      if (waiting && TIMEOUT_CYCLES != 0 && wait_cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      if (m.RREADY && m.RVALID) begin
        rsp_id <= m.RID;
        rsp_data <= m.RDATA;
        rsp_resp <= (m.RID != id_q || !m.RLAST) ? 2'b10 : m.RRESP;
      end
      if (m.BREADY && m.BVALID) begin
        rsp_id <= m.BID;
        rsp_data <= '0;
        rsp_resp <= (m.BID != id_q) ? 2'b10 : m.BRESP;
      end
      if (rsp_valid && rsp_ready) txn_count <= txn_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_rng_master.sv
// tb_axi_rng_master: scoreboard bench driving axi_rng_master against a behavioural RNG register slave
module tb_axi_rng_master;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_id;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [15:0] rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [15:0] txn_count;
  axi_rng_master_if bus();
  axi_rng_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .timeout_err(timeout_err), .txn_count(txn_count),
    .m(bus)
  );
  always #5 ACLK = ~ACLK;
  typedef struct {
    logic        w;
    logic [15:0] id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vecs = 0, miss = 0, exp_txn = 0;
  logic ar_silent = 1'b0, r_stall = 1'b0, id_flip = 1'b0, rlast_bad = 1'b0;
  int w_delay = 0, aw_n = 0, w_n = 0, b_n = 0, bready_rises = 0;
  logic [31:0] regs [4];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h, need %h", name, got, exp);
    end
  endtask
  // slave: drives its side at negedge; handshakes are detected from values saved at the previous negedge
  initial begin : slave
    logic s_arv, s_awv, s_wv, s_rr, s_br, got_aw, got_w, last_br;
    logic [31:0] s_araddr, s_awaddr, s_wdata, aw_addr, w_data;
    logic [15:0] s_arid, s_awid, aw_id;
    logic [3:0] s_wstrb, w_strb;
    int wcnt;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BID = '0; bus.BRESP = '0;
    s_arv = 0; s_awv = 0; s_wv = 0; s_rr = 0; s_br = 0; got_aw = 0; got_w = 0; last_br = 0;
    s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_arid = '0; s_awid = '0; s_wstrb = '0;
    aw_addr = '0; w_data = '0; aw_id = '0; w_strb = '0; wcnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        bus.ARREADY = 0; bus.RVALID = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0;
        got_aw = 0; got_w = 0;
      end else begin
        if (bus.RVALID && s_rr) bus.RVALID = 0;
        if (bus.ARREADY && s_arv) begin
          bus.ARREADY = 0;
          if (!r_stall) begin
            bus.RVALID = 1;
            bus.RID = s_arid ^ {id_flip, 15'b0};
            bus.RLAST = !rlast_bad;
            bus.RDATA = (s_araddr < 16) ? regs[s_araddr[3:2]] : 32'hDEADBEEF;
            bus.RRESP = (s_araddr < 16) ? 2'b00 : 2'b10;
          end
        end else bus.ARREADY = bus.ARVALID && !ar_silent && !bus.RVALID;
        if (bus.AWREADY && s_awv) begin
          bus.AWREADY = 0; got_aw = 1; aw_addr = s_awaddr; aw_id = s_awid; wcnt = w_delay; aw_n++;
        end else bus.AWREADY = bus.AWVALID && !ar_silent && !got_aw;
        if (bus.WREADY && s_wv) begin
          bus.WREADY = 0; got_w = 1; w_data = s_wdata; w_strb = s_wstrb; w_n++;
        end else if (got_aw && !got_w) begin
          if (wcnt > 0) wcnt--;
          else bus.WREADY = bus.WVALID;
        end
        if (bus.BVALID && s_br) begin
          bus.BVALID = 0; b_n++;
        end else if (got_aw && got_w && !bus.BVALID) begin
          if (aw_addr < 16)
            for (int i = 0; i < 4; i++) if (w_strb[i]) regs[aw_addr[3:2]][8*i +: 8] = w_data[8*i +: 8];
          bus.BVALID = 1;
          bus.BID = aw_id ^ {id_flip, 15'b0};
          bus.BRESP = (aw_addr < 16) ? 2'b00 : 2'b10;
          got_aw = 0; got_w = 0;
        end
      end
      if (bus.BREADY && !last_br) bready_rises++;
      last_br = bus.BREADY;
      s_arv = bus.ARVALID; s_araddr = bus.ARADDR; s_arid = bus.ARID; s_rr = bus.RREADY;
      s_awv = bus.AWVALID; s_awaddr = bus.AWADDR; s_awid = bus.AWID;
      s_wv = bus.WVALID; s_wdata = bus.WDATA; s_wstrb = bus.WSTRB[3:0]; s_br = bus.BREADY;
    end
  end
  always @(negedge ACLK) begin
    if (!ARESET && rsp_valid && rsp_ready) begin
      vecs++;
      if (q.size() == 0) begin
        miss++;
        $display("FAIL rsp_unexpected: got id=%h data=%h, need no response", rsp_id, rsp_data);
      end else begin
        e = q.pop_front();
        if ({rsp_write, rsp_id, rsp_data, rsp_resp} !== {e.w, e.id, e.data, e.resp}) begin
          miss++;
          $display("FAIL rsp_%h: got w=%b id=%h data=%h resp=%b, need w=%b id=%h data=%h resp=%b",
                   e.id, rsp_write, rsp_id, rsp_data, rsp_resp, e.w, e.id, e.data, e.resp);
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [15:0] id, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic expect_rsp, input logic [15:0] eid,
                       input logic [31:0] edata, input logic [1:0] eresp);
    int n = 0;
    if (expect_rsp) begin
      q.push_back('{w, eid, edata, eresp});
      exp_txn++;
    end
    @(posedge ACLK); #2;
    cmd_valid = 1; cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    while (!cmd_ready && n < 100) begin @(posedge ACLK); #2; n++; end
    vecs++;
    if (!cmd_ready) begin
      miss++;
      $display("FAIL cmd_accept_%h: cmd_ready got 0, need 1", id);
    end
    @(posedge ACLK); #2;
    cmd_valid = 0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < 200) begin @(posedge ACLK); #2; n++; end
    vecs++;
    if (q.size() != 0 || !cmd_ready) begin
      miss++;
      $display("FAIL %s_done: got %0d responses pending, need 0", name, q.size());
    end
    chk({name, "_txn_count"}, 32'(txn_count), 32'(exp_txn));
  endtask
  initial begin : stim
    int a0, w0, b0, br0, n;
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_id = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    repeat (3) @(posedge ACLK);
    #2;
    chk("reset_valids", {bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, rsp_valid}, 0);
    chk("reset_addr", bus.ARADDR | bus.AWADDR | bus.WDATA | 32'(bus.ARID), 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_txn_count", txn_count, 0);
    chk("reset_timeout", timeout_err, 0);
    chk("fixed_fields", {bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.AWLEN, bus.AWSIZE, bus.AWBURST},
        {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01});
    ARESET = 0;
    issue(1, 16'h0011, 32'h8, 32'h00001234, 4'hF, 1, 16'h0011, 32'h0, 2'b00);
    wait_done("wr_seed");
    chk("wr_seed_aw_n", aw_n, 1);
    chk("wr_seed_w_n", w_n, 1);
    chk("wr_seed_b_n", b_n, 1);
    issue(0, 16'h0022, 32'h8, 32'h0, 4'h0, 1, 16'h0022, 32'h00001234, 2'b00);
    wait_done("rd_seed");
    issue(0, 16'h0033, 32'h100, 32'h0, 4'h0, 1, 16'h0033, 32'hDEADBEEF, 2'b10);
    wait_done("rd_unmapped");
    w_delay = 3; a0 = aw_n; w0 = w_n; b0 = b_n; br0 = bready_rises;
    issue(1, 16'h0044, 32'hC, 32'hA5A5A5A5, 4'b0011, 1, 16'h0044, 32'h0, 2'b00);
    wait_done("wr_delay");
    chk("wr_delay_aw_n", aw_n - a0, 1);
    chk("wr_delay_w_n", w_n - w0, 1);
    chk("wr_delay_b_n", b_n - b0, 1);
    chk("wr_delay_bready_windows", bready_rises - br0, 1);
    w_delay = 0;
    issue(0, 16'h0045, 32'hC, 32'h0, 4'h0, 1, 16'h0045, 32'h0000A5A5, 2'b00);
    wait_done("rd_count");
    id_flip = 1;
    issue(0, 16'h0055, 32'h8, 32'h0, 4'h0, 1, 16'h8055, 32'h00001234, 2'b10);
    wait_done("rd_badid");
    issue(1, 16'h0077, 32'h0, 32'hCAFEF00D, 4'hF, 1, 16'h8077, 32'h0, 2'b10);
    wait_done("wr_badid");
    id_flip = 0; rlast_bad = 1;
    issue(0, 16'h0066, 32'h4, 32'h0, 4'h0, 1, 16'h0066, 32'h0, 2'b10);
    wait_done("rd_nolast");
    rlast_bad = 0;
    issue(0, 16'h0078, 32'h0, 32'h0, 4'h0, 1, 16'h0078, 32'hCAFEF00D, 2'b00);
    wait_done("rd_data");
    rsp_ready = 0;
    issue(0, 16'h0088, 32'h8, 32'h0, 4'h0, 1, 16'h0088, 32'h00001234, 2'b00);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge ACLK); #2; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, 32'h00001234);
      chk("hold_rsp_id", rsp_id, 16'h0088);
      chk("hold_rsp_resp", rsp_resp, 2'b00);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_txn_count", txn_count, 32'(exp_txn - 1));
      @(posedge ACLK); #2;
    end
    rsp_ready = 1;
    wait_done("hold");
    chk("pre_timeout", timeout_err, 0);
    ar_silent = 1;
    issue(0, 16'h0099, 32'h4, 32'h0, 4'h0, 0, 16'h0, 32'h0, 2'b00);
    repeat (15) begin @(posedge ACLK); #2; end
    chk("timeout_at_15", timeout_err, 0);
    chk("arvalid_at_15", bus.ARVALID, 1);
    @(posedge ACLK); #2;
    chk("timeout_at_16", timeout_err, 1);
    chk("arvalid_at_16", bus.ARVALID, 1);
    chk("araddr_at_16", bus.ARADDR, 32'h4);
    r_stall = 1; ar_silent = 0;
    n = 0;
    while (!bus.RREADY && n < 20) begin @(posedge ACLK); #2; n++; end
    chk("in_rdata", bus.RREADY, 1);
    ARESET = 1;
    #1;
    chk("arst_valids", {bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, rsp_valid}, 0);
    chk("arst_idle", cmd_ready, 1);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_txn_count", txn_count, 0);
    repeat (2) @(posedge ACLK);
    #2;
    chk("arst_no_rsp", rsp_valid, 0);
    ARESET = 0; r_stall = 0; exp_txn = 0;
    issue(0, 16'h00AB, 32'h8, 32'h0, 4'h0, 1, 16'h00AB, 32'h00001234, 2'b00);
    wait_done("post_reset");
    chk("leftover_expected", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, need completion");
    $fatal(1, "watchdog");
  end
endmodule
